// File: rtl/negation_arbiter.sv
// -----------------------------------------------------------------------------
// negation_arbiter
//
// Purpose:
//   Shares one external 32-bit bitwise-inverter datapath among N_REQ
//   requesters. A round-robin arbiter picks one pending request at a time.
//   The operand goes out on not_a and the inverter result comes back on not_c.
//   For NEG requests, +1 is added to the result to form the two's complement.
//   The result returns with the requester index on a valid/ready response
//   channel. Only one operation is in flight at a time.
//
// Parameters:
//   N_REQ   number of requesters (>= 2)
//   DATA_W  operand/result width. The inverter datapath is 32 bits wide, so
//           only 32 is supported.
//   ID_W    requester index width, derived from N_REQ
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   req_valid  per-requester request valid
//   req_op     per-requester op: 0 = NOT (~a), 1 = NEG (~a + 1)
//   req_data   per-requester operands; slot i = req_data[i*DATA_W +: DATA_W]
//   req_ready  one-hot accept strobe, high only in IDLE for the granted slot
//   not_a      operand driven to the shared inverter
//   not_c      inverter result (combinational function of not_a)
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_data   result
//   rsp_id     index of the requester that was served
//   rsp_ovf    NEG overflow (operand is the most negative value)
// -----------------------------------------------------------------------------
module negation_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 32,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       not_a,
  input  logic [DATA_W-1:0]       not_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Most negative two's-complement value; negating it overflows back to itself.
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic              op_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_op;
  logic [DATA_W-1:0] grant_data;

  // Unpacked view of the flat operand bus so the grant mux can index by slot.
  logic [DATA_W-1:0] slot_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin search. Start at rr_ptr, wrap at N_REQ-1 -> 0, and take the
  // first valid slot.
  always_comb begin
    int              slot;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_op    = 1'b0;
    grant_data  = '0;
    slot        = 0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= N_REQ) begin
        slot = slot - N_REQ;
      end
      idx = ID_W'(slot);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
        grant_op    = req_op[idx];
        grant_data  = slot_data[idx];
      end
    end
  end

  // The accept strobe is combinational so that the handshake lands in the
  // same IDLE cycle that the grant is made. It is masked while rst_n is low,
  // so nothing is accepted during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Control FSM and datapath registers. Each operation takes three states:
  // IDLE (accept), CALC (capture the inverter result), and RESP (hold until
  // the consumer takes it). This is why throughput tops out at one operation
  // every three cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_q      <= 1'b0;
      not_a     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            not_a <= grant_data;
            op_q  <= grant_op;
            id_q  <= grant_idx;
            state <= CALC;
          end
        end
        CALC: begin
          // not_c already reflects not_a, which was registered at accept.
          rsp_data  <= op_q ? (not_c + DATA_W'(1)) : not_c;
          rsp_ovf   <= op_q & (not_a == MIN_NEG);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // The pointer advances past the requester just served, which
            // gives every waiting requester a turn within N_REQ grants.
            rr_ptr    <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
